// File: rtl/mux_l2_tx.sv
// mux_l2_tx: two-lane byte transmit multiplexer.
//   Each lane feeds a DEPTH-entry FIFO; the output stream alternates slot
//   ownership every clk_4f cycle (lane 0, lane 1, lane 0, ...). An owning
//   lane with an empty FIFO leaves its slot idle; the other lane never
//   borrows it, so a phase-matched demux can recover both lanes.
// Ports:
//   clk_4f               sole clock
//   reset                asynchronous active-high reset
//   data_00/valid_00     lane-0 byte in,  ready_00 lane-0 FIFO not full
//   data_11/valid_11     lane-1 byte in,  ready_11 lane-1 FIFO not full
//   data_000/valid_000   serialized byte stream and its qualifier
//   slot_11              current slot owner (0 = lane 0, 1 = lane 1)
//   ovf[1:0]             sticky per-lane overflow (byte dropped while full)
module mux_l2_tx #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic [7:0] data_00,
    input  logic       valid_00,
    output logic       ready_00,
    input  logic [7:0] data_11,
    input  logic       valid_11,
    output logic       ready_11,
    output logic [7:0] data_000,
    output logic       valid_000,
    output logic       slot_11,
    output logic [1:0] ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [7:0]    mem    [2][DEPTH];
    logic [AW-1:0] wr_ptr [2];
    logic [AW-1:0] rd_ptr [2];
    logic [CW-1:0] cnt    [2];

    logic [7:0] din [2];
    logic [1:0] valid_in;
    logic [1:0] ready;
    logic [1:0] push;
    logic [1:0] pop;

    always_comb begin
        din[0]   = data_00;
        din[1]   = data_11;
        valid_in = {valid_11, valid_00};
        // ready comes from the registered count only: a pop on this edge
        // does not make room for a push on the same edge.
        ready[0] = (cnt[0] != FULL);
        ready[1] = (cnt[1] != FULL);
        push     = valid_in & ready;
        // Pop decision uses the pre-edge slot owner; a byte pushed on this
        // edge is not yet counted, so it can never be popped on the same edge.
        pop[0]   = !slot_11 && (cnt[0] != '0);
        pop[1]   =  slot_11 && (cnt[1] != '0);
    end

    assign ready_00 = ready[0];
    assign ready_11 = ready[1];

    // FIFO storage needs no reset: contents are unreachable once counts clear.
    always_ff @(posedge clk_4f) begin
        for (int unsigned l = 0; l < 2; l++) begin
            if (push[l]) begin
                mem[l][wr_ptr[l]] <= din[l];
            end
        end
    end

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            slot_11   <= 1'b0;
            data_000  <= '0;
            valid_000 <= 1'b0;
            ovf       <= '0;
            for (int unsigned l = 0; l < 2; l++) begin
                wr_ptr[l] <= '0;
                rd_ptr[l] <= '0;
                cnt[l]    <= '0;
            end
        end else begin
            slot_11   <= ~slot_11;
            valid_000 <= |pop;
            if (pop[0]) begin
                data_000 <= mem[0][rd_ptr[0]];
            end else if (pop[1]) begin
                data_000 <= mem[1][rd_ptr[1]];
            end
            for (int unsigned l = 0; l < 2; l++) begin
                if (push[l]) begin
                    wr_ptr[l] <= wr_ptr[l] + 1'b1;
                end
                if (pop[l]) begin
                    rd_ptr[l] <= rd_ptr[l] + 1'b1;
                end
                if (push[l] && !pop[l]) begin
                    cnt[l] <= cnt[l] + 1'b1;
                end else if (pop[l] && !push[l]) begin
                    cnt[l] <= cnt[l] - 1'b1;
                end
                if (valid_in[l] && !ready[l]) begin
                    ovf[l] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_l2_tx.sv
// Testbench for mux_l2_tx: per-lane scoreboard queues filled when a byte is
// accepted, drained when the DUT emits a valid byte in that lane's slot.
module tb_mux_l2_tx;

    localparam int unsigned DEPTH = 4;

    logic       clk_4f = 1'b0;
    logic       reset  = 1'b1;
    logic [7:0] data_00  = '0;
    logic       valid_00 = 1'b0;
    logic       ready_00;
    logic [7:0] data_11  = '0;
    logic       valid_11 = 1'b0;
    logic       ready_11;
    logic [7:0] data_000;
    logic       valid_000;
    logic       slot_11;
    logic [1:0] ovf;

    mux_l2_tx #(.DEPTH(DEPTH)) dut (
        .clk_4f    (clk_4f),
        .reset     (reset),
        .data_00   (data_00),
        .valid_00  (valid_00),
        .ready_00  (ready_00),
        .data_11   (data_11),
        .valid_11  (valid_11),
        .ready_11  (ready_11),
        .data_000  (data_000),
        .valid_000 (valid_000),
        .slot_11   (slot_11),
        .ovf       (ovf)
    );

    always #5 clk_4f = ~clk_4f;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference state
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         m_cnt[2];
    logic       m_slot;
    logic [1:0] m_ovf;
    logic [7:0] m_last;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        q0.delete();
        q1.delete();
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        m_slot   = 1'b0;
        m_ovf    = 2'b00;
        m_last   = 8'h00;
    endtask

    // One clk_4f cycle: drive inputs, predict, step an edge, compare.
    task automatic cycle(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
        logic acc0, acc1, exp_v, lane;
        logic [7:0] exp_d;
        valid_00 = v0; data_00 = d0;
        valid_11 = v1; data_11 = d1;
        check_eq("ready_00", ready_00, m_cnt[0] != DEPTH);
        check_eq("ready_11", ready_11, m_cnt[1] != DEPTH);
        acc0 = v0 && (m_cnt[0] != DEPTH);
        acc1 = v1 && (m_cnt[1] != DEPTH);
        if (acc0) q0.push_back(d0); else if (v0) m_ovf[0] = 1'b1;
        if (acc1) q1.push_back(d1); else if (v1) m_ovf[1] = 1'b1;
        lane  = m_slot;
        exp_v = lane ? (m_cnt[1] > 0) : (m_cnt[0] > 0);
        @(posedge clk_4f);
        #1;
        m_cnt[0] = m_cnt[0] + int'(acc0) - int'(exp_v && !lane);
        m_cnt[1] = m_cnt[1] + int'(acc1) - int'(exp_v && lane);
        m_slot   = !m_slot;
        check_eq("slot_11", slot_11, m_slot);
        check_eq("ovf", ovf, m_ovf);
        check_eq("valid_000", valid_000, exp_v);
        if (exp_v) begin
            exp_d = lane ? q1.pop_front() : q0.pop_front();
            check_eq(lane ? "data_lane1" : "data_lane0", data_000, exp_d);
            m_last = exp_d;
        end else begin
            check_eq("data_hold", data_000, m_last);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    // Asynchronous reset applied mid-cycle, pushes attempted while held.
    task automatic apply_reset();
        #2 reset = 1'b1;
        #1;
        check_eq("rst_valid", valid_000, 1'b0);
        check_eq("rst_data", data_000, 8'h00);
        check_eq("rst_slot", slot_11, 1'b0);
        check_eq("rst_ovf", ovf, 2'b00);
        check_eq("rst_ready_00", ready_00, 1'b1);
        check_eq("rst_ready_11", ready_11, 1'b1);
        model_clear();
        valid_00 = 1'b1; data_00 = 8'hEE;
        valid_11 = 1'b1; data_11 = 8'hDD;
        @(posedge clk_4f);
        #1;
        check_eq("rst_hold_valid", valid_000, 1'b0);
        check_eq("rst_hold_ready", {ready_11, ready_00}, 2'b11);
        @(negedge clk_4f);
        valid_00 = 1'b0;
        valid_11 = 1'b0;
        reset    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        repeat (2) @(posedge clk_4f);
        apply_reset();

        // Alternation: push both lanes on an edge whose pre-edge owner is lane 1,
        // so lane 0 gets the next slot (A1) and lane 1 the one after (B1).
        idle(1);
        cycle(1'b1, 8'hA1, 1'b1, 8'hB1);
        idle(3);

        // Lane 0 only, one byte per two cycles: lane-1 slots stay idle.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'h10 + 8'(i), 1'b0, 8'h00);
            idle(1);
        end
        idle(2);

        // Lane 1 held valid at full rate while drained at half rate: fills, drops, ovf[1].
        for (int i = 0; i < 14; i++) cycle(1'b0, 8'h00, 1'b1, 8'h20 + 8'(i));
        idle(10);

        // Reset with both FIFOs non-empty: contents discarded, slot restarts.
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h60 + 8'(i), 1'b1, 8'h70 + 8'(i));
        apply_reset();
        idle(6);

        // Wrap-around: 3*DEPTH bytes per lane at half rate, no loss, ovf stays 0.
        for (int i = 0; i < 3 * DEPTH; i++) begin
            cycle(1'b1, 8'h40 + 8'(i), 1'b1, 8'h80 + 8'(i));
            idle(1);
        end
        idle(6);
        check_eq("wrap_ovf", ovf, 2'b00);

        // Loopback: random lane traffic, recovered per slot parity.
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 2) == 0, 8'($urandom));
        end
        idle(12);
        check_eq("drain_lane0", q0.size(), 0);
        check_eq("drain_lane1", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mux_l2_tx.md
MUX_L2_TX -- requirements
Module: mux_l2_tx

Interface
REQ-001 SHALL have port clk_4f  input  1  sole clock; all state updates on posedge clk_4f.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port data_00  input  8  lane-0 byte.
REQ-004 SHALL have port valid_00  input  1  lane-0 byte valid.
REQ-005 SHALL have port ready_00  output  1  lane-0 FIFO can accept a byte.
REQ-006 SHALL have port data_11  input  8  lane-1 byte.
REQ-007 SHALL have port valid_11  input  1  lane-1 byte valid.
REQ-008 SHALL have port ready_11  output  1  lane-1 FIFO can accept a byte.
REQ-009 SHALL have port data_000  output  8  serialized byte stream, one byte slot per clk_4f cycle.
REQ-010 SHALL have port valid_000  output  1  data_000 qualifier.
REQ-011 SHALL have port slot_11  output  1  current slot owner: 0 = lane 0, 1 = lane 1 (half-rate phase, clk_2f equivalent).
REQ-012 SHALL have port ovf  output  2  sticky overflow flags, [0] lane 0, [1] lane 1.
REQ-013 SHALL have parameter DEPTH, default 4, per-lane FIFO depth, power of two, at least 2.

Function
REQ-014 SHALL provide one DEPTH-entry FIFO per lane, with pointers of log2(DEPTH) bits that wrap modulo DEPTH and a count of log2(DEPTH)+1 bits.
REQ-015 SHALL drive ready_xx = (count_xx != DEPTH), from registered count only; a pop in the same cycle does not raise ready.
REQ-016 SHALL push on posedge when valid_xx && ready_xx.
REQ-017 SHALL drop the byte when valid_xx && !ready_xx, and set ovf[x], which stays 1 until reset.
REQ-018 SHALL toggle slot_11 every clk_4f cycle from the first edge after reset release: 0,1,0,1...
REQ-019 SHALL, on an edge where slot_11 = 0 and lane-0 count > 0, pop lane 0, register its head into data_000 and set valid_000 = 1.
REQ-020 SHALL, on an edge where slot_11 = 1, apply the REQ-019 rule to lane 1.
REQ-021 SHALL, when the owning lane is empty, set valid_000 = 0 and hold data_000 at its previous value; the other lane SHALL NOT borrow the slot.
REQ-022 SHALL give a minimum latency of 1 cycle from push edge to output: a byte pushed at edge N is popped at the first edge > N where slot_11 matches its lane; data_000 is valid after that edge.
REQ-023 SHALL, on simultaneous push and pop on one lane, leave count unchanged and keep both pointers advancing; on an empty FIFO, a byte pushed at edge N SHALL NOT be popped at edge N.
REQ-024 SHALL emit lane-0 bytes in even slots and lane-1 bytes in odd slots, so a demux that assigns the first byte after reset to lane 0 recovers both lanes.
REQ-025 SHALL keep each lane's output in FIFO order; there is no reordering.

Reset
REQ-026 SHALL, while reset = 1, force data_000 = 8'h00, valid_000 = 0, slot_11 = 0, ovf = 2'b00, all pointers and counts = 0, regardless of clk_4f.
REQ-027 SHALL give ready_00 = ready_11 = 1 while reset = 1 and after release; pushes during reset are ignored.
REQ-028 SHALL, on reset asserted mid-operation, discard all FIFO contents, with no byte emitted after release until a new push.

Verification
REQ-029 SHALL cover lane alternation: after reset, push 8'hA1 on lane 0 and 8'hB1 on lane 1 on the same edge -> data_000 = A1 (valid, slot 0) then B1 (valid, slot 1).
REQ-030 SHALL cover empty slots: push lane 0 only with 10,11,12 one per two cycles -> valid_000 pulses only in slot 0; lane-1 slots show valid_000 = 0 and data_000 held.
REQ-031 SHALL cover full/overflow: hold valid_11 = 1 with bytes 20..27 while lane 1 is drained -> order preserved 20,21,...; with a stalled drain (ownership mismatch) ready_11 = 0 at count 4 and ovf[1] = 1 sticky.
REQ-032 SHALL cover wrap-around: stream 3*DEPTH sequential bytes per lane at half rate -> output is an exact interleave with no loss and ovf = 0.
REQ-033 SHALL cover reset mid-stream: assert reset with both FIFOs non-empty -> immediate valid_000 = 0 and data_000 = 0; after release, no stale byte appears and slot_11 restarts at 0.
REQ-034 SHALL cover loopback: connect to the lane demux at matched phase with random lane traffic -> recovered lanes equal the transmitted lanes.
